// File: rtl/rs_issue_select_if.sv
// rtl/rs_issue_select_if.sv - reservation-station to issue-select bundle and issue bus
interface rs_issue_select_if #(
    parameter int N_ENTRIES = 5,
    parameter int PKT_W     = 64,
    parameter int IDX_W     = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1
);
    logic [N_ENTRIES-1:0]       rs_ready;
    logic [2*N_ENTRIES-1:0]     rs_fu;
    logic [PKT_W*N_ENTRIES-1:0] rs_packet;
    logic                       alu_ready;
    logic                       mult_ready;
    logic                       mem_done;
    logic                       flush;

    logic [N_ENTRIES-1:0]       free;
    logic                       alu_valid;
    logic                       mem_valid;
    logic                       mult_valid;
    logic [1:0]                 issue_fu;
    logic [IDX_W-1:0]           issue_entry;
    logic [PKT_W-1:0]           issue_packet;

    // Station / unit side: drives entry state and unit status, receives issues
    modport master (
        output rs_ready, rs_fu, rs_packet, alu_ready, mult_ready, mem_done, flush,
        input  free, alu_valid, mem_valid, mult_valid, issue_fu, issue_entry, issue_packet
    );

    // Selector side
    modport slave (
        input  rs_ready, rs_fu, rs_packet, alu_ready, mult_ready, mem_done, flush,
        output free, alu_valid, mem_valid, mult_valid, issue_fu, issue_entry, issue_packet
    );
endinterface

// File: rtl/rs_issue_select.sv
// rtl/rs_issue_select.sv - round-robin single-issue selector with memory-busy and re-issue masking
module rs_issue_select #(
    parameter int N_ENTRIES = 5,
    parameter int PKT_W     = 64
) (
    input  logic               clock,
    input  logic               reset,
    rs_issue_select_if.slave   bus
);
    localparam int IDX_W = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;

    localparam logic [1:0] FU_ALU   = 2'd0;
    localparam logic [1:0] FU_LOAD  = 2'd1;
    localparam logic [1:0] FU_STORE = 2'd2;
    localparam logic [1:0] FU_MULT  = 2'd3;

    logic [IDX_W-1:0]     r_rr_ptr;
    logic [N_ENTRIES-1:0] r_pending;
    logic                 r_mem_busy;
    logic [N_ENTRIES-1:0] r_free;
    logic                 r_alu_valid;
    logic                 r_mem_valid;
    logic                 r_mult_valid;
    logic [1:0]           r_issue_fu;
    logic [IDX_W-1:0]     r_issue_entry;
    logic [PKT_W-1:0]     r_issue_packet;

    logic                 w_mem_avail;
    logic [N_ENTRIES-1:0] w_cand;
    logic                 w_found;
    logic [IDX_W-1:0]     w_win;
    logic [1:0]           w_win_fu;
    logic [PKT_W-1:0]     w_win_pkt;
    logic                 w_win_is_mem;
    logic [IDX_W-1:0]     w_next_ptr;

    // A memory op may be picked in the cycle the previous one completes
    assign w_mem_avail = ~r_mem_busy | bus.mem_done;

    // Per-entry candidacy: ready, not already issued, and its unit can take it
    always_comb begin
        w_cand = '0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            logic v_avail;
            case (bus.rs_fu[2*i +: 2])
                FU_ALU:   v_avail = bus.alu_ready;
                FU_MULT:  v_avail = bus.mult_ready;
                default:  v_avail = w_mem_avail;
            endcase
            w_cand[i] = bus.rs_ready[i] & ~r_pending[i] & v_avail;
        end
    end

    // Round-robin scan starting at r_rr_ptr; first candidate found wins
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int off = 0; off < N_ENTRIES; off++) begin
            logic [IDX_W:0] v_idx;
            v_idx = {1'b0, r_rr_ptr} + (IDX_W+1)'(off);
            if (v_idx >= (IDX_W+1)'(N_ENTRIES)) begin
                v_idx = v_idx - (IDX_W+1)'(N_ENTRIES);
            end
            if (!w_found && w_cand[v_idx[IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_win   = v_idx[IDX_W-1:0];
            end
        end
    end

    assign w_win_fu     = bus.rs_fu[int'(w_win)*2 +: 2];
    assign w_win_pkt    = bus.rs_packet[int'(w_win)*PKT_W +: PKT_W];
    assign w_win_is_mem = w_found && (w_win_fu == FU_LOAD || w_win_fu == FU_STORE);
    assign w_next_ptr   = (w_win == IDX_W'(N_ENTRIES-1)) ? '0 : w_win + 1'b1;

    // Register the selected issue, update pointer, pending mask and memory busy
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rr_ptr       <= '0;
            r_pending      <= '0;
            r_mem_busy     <= 1'b0;
            r_free         <= '0;
            r_alu_valid    <= 1'b0;
            r_mem_valid    <= 1'b0;
            r_mult_valid   <= 1'b0;
            r_issue_fu     <= '0;
            r_issue_entry  <= '0;
            r_issue_packet <= '0;
        end else if (bus.flush) begin
            r_pending      <= '0;
            r_mem_busy     <= 1'b0;
            r_free         <= '0;
            r_alu_valid    <= 1'b0;
            r_mem_valid    <= 1'b0;
            r_mult_valid   <= 1'b0;
        end else begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                if (w_found && w_win == IDX_W'(i)) begin
                    r_pending[i] <= 1'b1;
                end else if (!bus.rs_ready[i]) begin
                    r_pending[i] <= 1'b0;
                end
            end

            if (w_win_is_mem) begin
                r_mem_busy <= 1'b1;
            end else if (bus.mem_done) begin
                r_mem_busy <= 1'b0;
            end

            r_alu_valid  <= w_found && (w_win_fu == FU_ALU);
            r_mem_valid  <= w_win_is_mem;
            r_mult_valid <= w_found && (w_win_fu == FU_MULT);
            r_free       <= '0;

            if (w_found) begin
                r_rr_ptr          <= w_next_ptr;
                r_free[w_win]     <= 1'b1;
                r_issue_fu        <= w_win_fu;
                r_issue_entry     <= w_win;
                r_issue_packet    <= w_win_pkt;
            end
        end
    end

    assign bus.free         = r_free;
    assign bus.alu_valid    = r_alu_valid;
    assign bus.mem_valid    = r_mem_valid;
    assign bus.mult_valid   = r_mult_valid;
    assign bus.issue_fu     = r_issue_fu;
    assign bus.issue_entry  = r_issue_entry;
    assign bus.issue_packet = r_issue_packet;
endmodule

// File: tb/tb_rs_issue_select.sv
// tb/tb_rs_issue_select.sv - directed cycle-vector bench for rs_issue_select
module tb_rs_issue_select;
    localparam int N = 5;
    localparam int P = 64;

    logic clock;
    logic reset;

    rs_issue_select_if #(.N_ENTRIES(N), .PKT_W(P)) bus ();

    rs_issue_select #(.N_ENTRIES(N), .PKT_W(P)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       rst;
        logic       fl;
        logic [4:0] rdy;
        logic [9:0] fu;
        logic       alu;
        logic       mul;
        logic       done;
        logic [2:0] ev;     // {mult, mem, alu}
        logic [4:0] efree;
        int         eent;
        logic [1:0] efu;
    } vec_t;

    vec_t vecs[$];
    int   passed = 0;
    int   total  = 0;

    function automatic logic [P-1:0] pkt(input int i);
        return 64'hC0DE_5A00_0000_0000 + 64'(i) * 64'h0001_0001_0001;
    endfunction

    task automatic check(input string name, input int row, input logic [P-1:0] act, input logic [P-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    endtask

    task automatic add(input logic rst, input logic fl, input logic [4:0] rdy, input logic [9:0] fu,
                       input logic alu, input logic mul, input logic done,
                       input logic [2:0] ev, input logic [4:0] efree, input int eent, input logic [1:0] efu);
        vec_t v;
        v.rst = rst; v.fl = fl; v.rdy = rdy; v.fu = fu; v.alu = alu; v.mul = mul; v.done = done;
        v.ev = ev; v.efree = efree; v.eent = eent; v.efu = efu;
        vecs.push_back(v);
    endtask

    task automatic step(input vec_t v, input int row);
        @(negedge clock);
        reset          = v.rst;
        bus.flush      = v.fl;
        bus.rs_ready   = v.rdy;
        bus.rs_fu      = v.fu;
        bus.alu_ready  = v.alu;
        bus.mult_ready = v.mul;
        bus.mem_done   = v.done;
        @(posedge clock);
        #1;
        check("alu_valid",  row, 64'(bus.alu_valid),  64'(v.ev[0]));
        check("mem_valid",  row, 64'(bus.mem_valid),  64'(v.ev[1]));
        check("mult_valid", row, 64'(bus.mult_valid), 64'(v.ev[2]));
        check("free",       row, 64'(bus.free),       64'(v.efree));
        if (v.rst || v.ev != 3'b000) begin
            check("issue_entry",  row, 64'(bus.issue_entry), 64'(v.eent));
            check("issue_fu",     row, 64'(bus.issue_fu),    64'(v.efu));
            check("issue_packet", row, bus.issue_packet, v.rst ? 64'd0 : pkt(v.eent));
        end
    endtask

    localparam logic [9:0] FU_ALL_ALU  = 10'b00_00_00_00_00;
    localparam logic [9:0] FU_ALL_MULT = 10'b11_11_11_11_11;
    localparam logic [9:0] FU_LD1_ST2  = 10'b00_00_10_01_00;
    localparam logic [9:0] FU_MU3      = 10'b00_11_00_00_00;
    localparam logic [9:0] FU_LD1      = 10'b00_00_00_01_00;

    initial begin
        reset          = 1'b1;
        bus.flush      = 1'b0;
        bus.rs_ready   = '0;
        bus.rs_fu      = '0;
        bus.alu_ready  = 1'b0;
        bus.mult_ready = 1'b0;
        bus.mem_done   = 1'b0;
        for (int i = 0; i < N; i++) bus.rs_packet[i*P +: P] = pkt(i);

        //   rst fl  rdy       fu           alu  mul  done ev      free      ent fu
        // single ALU entry, then no reissue while it stays ready
        add(1, 0, 5'b00000, FU_ALL_ALU,  0, 0, 0, 3'b000, 5'b00000, 0, 0);
        add(0, 0, 5'b00001, FU_ALL_ALU,  1, 0, 0, 3'b001, 5'b00001, 0, 0);
        add(0, 0, 5'b00001, FU_ALL_ALU,  1, 0, 0, 3'b000, 5'b00000, 0, 0);
        add(0, 0, 5'b00001, FU_ALL_ALU,  1, 0, 0, 3'b000, 5'b00000, 0, 0);
        add(0, 0, 5'b00000, FU_ALL_ALU,  1, 0, 0, 3'b000, 5'b00000, 0, 0);
        // all MULT, round-robin 0..4 then wrap to 0
        add(1, 0, 5'b00000, FU_ALL_MULT, 0, 0, 0, 3'b000, 5'b00000, 0, 0);
        add(0, 0, 5'b11111, FU_ALL_MULT, 0, 1, 0, 3'b100, 5'b00001, 0, 3);
        add(0, 0, 5'b11110, FU_ALL_MULT, 0, 1, 0, 3'b100, 5'b00010, 1, 3);
        add(0, 0, 5'b11101, FU_ALL_MULT, 0, 1, 0, 3'b100, 5'b00100, 2, 3);
        add(0, 0, 5'b11011, FU_ALL_MULT, 0, 1, 0, 3'b100, 5'b01000, 3, 3);
        add(0, 0, 5'b10111, FU_ALL_MULT, 0, 1, 0, 3'b100, 5'b10000, 4, 3);
        add(0, 0, 5'b01111, FU_ALL_MULT, 0, 1, 0, 3'b100, 5'b00001, 0, 3);
        add(0, 0, 5'b00000, FU_ALL_MULT, 0, 1, 0, 3'b000, 5'b00000, 0, 0);
        // LOAD then STORE held until mem_done; busy survives done+issue
        add(0, 0, 5'b00110, FU_LD1_ST2,  0, 0, 0, 3'b010, 5'b00010, 1, 1);
        add(0, 0, 5'b00100, FU_LD1_ST2,  0, 0, 0, 3'b000, 5'b00000, 0, 0);
        add(0, 0, 5'b00100, FU_LD1_ST2,  0, 0, 0, 3'b000, 5'b00000, 0, 0);
        add(0, 0, 5'b00100, FU_LD1_ST2,  0, 0, 1, 3'b010, 5'b00100, 2, 2);
        add(0, 0, 5'b00010, FU_LD1_ST2,  0, 0, 0, 3'b000, 5'b00000, 0, 0);
        add(0, 0, 5'b00010, FU_LD1_ST2,  0, 0, 1, 3'b010, 5'b00010, 1, 1);
        add(0, 0, 5'b00000, FU_LD1_ST2,  0, 0, 1, 3'b000, 5'b00000, 0, 0);
        add(0, 0, 5'b00010, FU_LD1_ST2,  0, 0, 0, 3'b010, 5'b00010, 1, 1);
        // flush with memory busy and entry 1 pending
        add(0, 1, 5'b00011, FU_LD1_ST2,  1, 0, 0, 3'b000, 5'b00000, 0, 0);
        add(0, 0, 5'b00011, FU_LD1_ST2,  1, 0, 0, 3'b001, 5'b00001, 0, 0);
        add(0, 0, 5'b00010, FU_LD1_ST2,  1, 0, 0, 3'b010, 5'b00010, 1, 1);
        // MULT blocked by mult_ready, ALU behind it goes first
        add(0, 0, 5'b00000, FU_MU3,      1, 0, 0, 3'b000, 5'b00000, 0, 0);
        add(0, 0, 5'b11000, FU_MU3,      1, 0, 0, 3'b001, 5'b10000, 4, 0);
        add(0, 0, 5'b01000, FU_MU3,      1, 1, 0, 3'b100, 5'b01000, 3, 3);
        // reset with a memory op outstanding, then lowest ready index issues
        add(1, 0, 5'b11111, FU_LD1,      1, 1, 0, 3'b000, 5'b00000, 0, 0);
        add(0, 0, 5'b00110, FU_LD1,      1, 0, 0, 3'b010, 5'b00010, 1, 1);

        for (int r = 0; r < vecs.size(); r++) step(vecs[r], r);

        // stray mem_done while idle must not let a second memory op bypass busy
        begin
            vec_t v;
            v = '{rst:1, fl:0, rdy:5'b00000, fu:FU_LD1_ST2, alu:0, mul:0, done:0,
                  ev:3'b000, efree:5'b00000, eent:0, efu:2'd0};
            step(v, 100);
            v.rst = 0; v.done = 1;
            step(v, 101);
            v.done = 0; v.rdy = 5'b00010; v.ev = 3'b010; v.efree = 5'b00010; v.eent = 1; v.efu = 2'd1;
            step(v, 102);
            v.rdy = 5'b00100; v.ev = 3'b000; v.efree = 5'b00000;
            for (int k = 0; k < 3; k++) step(v, 103 + k);
            v.done = 1; v.ev = 3'b010; v.efree = 5'b00100; v.eent = 2; v.efu = 2'd2;
            step(v, 106);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/rs_issue_select.md
# rs_issue_select

Issue-select stage directly downstream of the reservation station. Each cycle it picks at most one ready entry, round-robin, whose functional unit can accept work. It registers that entry's packet onto the issue bus for the ALU, memory or multiplier unit, and pulses a free bit back to the reservation station. It also tracks the non-pipelined memory unit's busy state and masks entries already issued until the station deasserts them.

## Interface
- N_ENTRIES, 5, number of reservation-station entries (index width IDX_W = $clog2(N_ENTRIES))
- PKT_W, 64, opaque packet payload width, passed through unmodified
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- rs_ready  in  N_ENTRIES  entry i busy with both operands ready
- rs_fu  in  2*N_ENTRIES  FU class of entry i: 0 ALU, 1 LOAD, 2 STORE, 3 MULT
- rs_packet  in  PKT_W*N_ENTRIES  packet of entry i
- alu_ready  in  1  ALU accepts an op this cycle
- mult_ready  in  1  multiplier pipeline accepts an op this cycle
- mem_done  in  1  memory unit finished its current load/store (1-cycle pulse)
- flush  in  1  squash: cancel selection, clear tracking state
- free  out  N_ENTRIES  1-cycle pulse: release entry i
- alu_valid, mem_valid, mult_valid  out  1 each  1-cycle issue strobe per unit (at most one high)
- issue_fu  out  2  FU class of issued op
- issue_entry  out  IDX_W  entry index of issued op
- issue_packet  out  PKT_W  issued packet

## Operation
- Candidate i: rs_ready[i] & ~pending[i] & fu_avail(rs_fu[i]).
- fu_avail:
  - ALU = alu_ready.
  - MULT = mult_ready.
  - LOAD/STORE = ~mem_busy | mem_done. Back-to-back memory issue is allowed in the done cycle.
- Round-robin: scan i = rr_ptr, rr_ptr+1, … mod N_ENTRIES. The first candidate wins.
- On a win k:
  - rr_ptr <= (k+1) mod N_ENTRIES. Wrap from N_ENTRIES-1 to 0.
  - pending[k] <= 1.
  - The matching valid is asserted and issue_* is loaded.
  - free <= one-hot k.
- No candidate: all valids 0, free 0, rr_ptr unchanged. issue_* holds its last value (don't-care).
- pending[i] clears in any cycle rs_ready[i]==0. Set on issue dominates clear in the same cycle. This prevents re-issue while the station still shows the entry during free latency.
- mem_busy:
  - Set on LOAD/STORE issue.
  - Cleared on mem_done without a same-cycle memory issue.
  - Done plus new memory issue in the same cycle leaves it set.
- mem_done while ~mem_busy is ignored.
- flush:
  - No selection that cycle.
  - Next cycle all valids and free are 0, pending = 0, mem_busy = 0, rr_ptr unchanged.
  - flush dominates all other inputs.
- reset (including mid-operation): rr_ptr = 0, pending = 0, mem_busy = 0, all valids 0, free 0, issue_fu/issue_entry/issue_packet 0.

## Timing
- Selection is combinational in cycle t. All outputs are registered and visible in t+1 (latency 1).
- Valid and free are single-cycle strobes, with no hold or handshake. Availability is checked before selection, so the unit must capture the op in t+1.
- free[k] is asserted in the same cycle as the issue strobe for k.
- Peak throughput is 1 issue per cycle across all units.
- A memory op issued in t has mem_busy=1 from t+1. The next memory issue can be selected no earlier than the cycle mem_done is high.
- An entry issued in t is not a candidate again until rs_ready[i] has been seen low at least one cycle after issue.

## Test plan
- Reset, then rs_ready=5'b00001, entry 0 ALU, alu_ready=1 -> t+1: alu_valid=1, issue_entry=0, free=5'b00001, issue_packet=rs_packet[0]. Entry 0 is not reissued while rs_ready[0] stays high.
- All 5 entries MULT and ready, mult_ready=1, rs_ready dropped one cycle after each free -> issue order 0,1,2,3,4,0 (rr_ptr wraps), one per cycle.
- Entry 1 LOAD issued; entry 2 STORE ready. STORE is held until mem_done. STORE issues from the mem_done cycle (mem_valid next cycle) and mem_busy stays 1.
- Entry 3 MULT with mult_ready=0 and entry 4 ALU ready -> entry 4 issues; entry 3 issues once mult_ready=1.
- flush asserted while entry 0 is ready and mem_busy=1 -> next cycle no valid and free=0, mem_busy=0, pending cleared. Entry 0 issues the following cycle.
- reset asserted mid-stream with a memory op outstanding -> all outputs 0 next cycle and rr_ptr=0. The first issue after reset is the lowest ready index.
